// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - serial FPGA configuration frame loader with shadow/commit
// Optional CRC-8 frame check enabled by defining FPGA_CFG_LOADER_CRC_EN.
module fpga_cfg_loader #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         BRB_W     = 750,
    parameter int         BSB_W     = 1728,
    parameter int         LB_W      = 80,
    parameter int         IO_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_bit,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_abort,
    output logic [BRB_W-1:0] brbselect,
    output logic [BSB_W-1:0] bsbselect,
    output logic [LB_W-1:0]  lbselect,
    output logic [IO_W-1:0]  leftioselect,
    output logic [IO_W-1:0]  rightioselect,
    output logic [IO_W-1:0]  topioselect,
    output logic [IO_W-1:0]  bottomioselect,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int TOTAL = BRB_W + BSB_W + LB_W + 4 * IO_W;

`ifdef FPGA_CFG_LOADER_CRC_EN
    typedef enum logic [1:0] {HUNT, LOAD, CRC, COMMIT} state_t;
`else
    typedef enum logic [1:0] {HUNT, LOAD, COMMIT} state_t;
`endif

    state_t           state, state_next;
    logic [11:0]      bit_cnt;
    // Only the last 7 bits are kept; the incoming bit completes the 8-bit window.
    logic [6:0]       sync_q;
    logic [TOTAL-1:0] shadow;
    logic [TOTAL-1:0] cfg_q;
    logic             xfer;
    logic             sync_hit;
    logic             last_payload;

    assign cfg_ready    = (state != COMMIT);
    assign xfer         = cfg_valid && cfg_ready;
    assign sync_hit     = ({sync_q, cfg_bit} == SYNC_WORD);
    assign last_payload = (bit_cnt == 12'(TOTAL - 1));

`ifdef FPGA_CFG_LOADER_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_next;
    logic [6:0] crc_rx;
    logic [2:0] crc_cnt;
    logic       crc_ok;

    assign crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ cfg_bit) ? 8'h07 : 8'h00);
    assign crc_ok   = ({crc_rx, cfg_bit} == crc_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cfg_abort) begin
            state_next = HUNT;
        end else begin
            case (state)
                HUNT:   if (xfer && sync_hit) state_next = LOAD;
`ifdef FPGA_CFG_LOADER_CRC_EN
                LOAD:   if (xfer && last_payload) state_next = CRC;
                CRC:    if (xfer && crc_cnt == 3'd7) state_next = crc_ok ? COMMIT : HUNT;
`else
                LOAD:   if (xfer && last_payload) state_next = COMMIT;
`endif
                COMMIT: state_next = HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            sync_q   <= '0;
            shadow   <= '0;
            cfg_q    <= '0;
            cfg_done <= 1'b0;
`ifdef FPGA_CFG_LOADER_CRC_EN
            crc_q    <= '0;
            crc_rx   <= '0;
            crc_cnt  <= '0;
            cfg_err  <= 1'b0;
`endif
        end else if (cfg_abort) begin
            bit_cnt <= '0;
            sync_q  <= '0;
`ifdef FPGA_CFG_LOADER_CRC_EN
            crc_cnt <= '0;
`endif
        end else begin
            case (state)
                HUNT: if (xfer) begin
                    if (sync_hit) begin
                        sync_q   <= '0;
                        bit_cnt  <= '0;
                        cfg_done <= 1'b0;
`ifdef FPGA_CFG_LOADER_CRC_EN
                        crc_q    <= '0;
                        crc_cnt  <= '0;
`endif
                    end else begin
                        sync_q <= {sync_q[5:0], cfg_bit};
                    end
                end
                LOAD: if (xfer) begin
                    shadow  <= {shadow[TOTAL-2:0], cfg_bit};
                    bit_cnt <= bit_cnt + 12'd1;
`ifdef FPGA_CFG_LOADER_CRC_EN
                    crc_q   <= crc_next;
`endif
                end
`ifdef FPGA_CFG_LOADER_CRC_EN
                CRC: if (xfer) begin
                    crc_rx  <= {crc_rx[5:0], cfg_bit};
                    crc_cnt <= crc_cnt + 3'd1;
                    if (crc_cnt == 3'd7 && !crc_ok) cfg_err <= 1'b1;
                end
`endif
                COMMIT: begin
                    cfg_q    <= shadow;
                    cfg_done <= 1'b1;
                    sync_q   <= '0;
`ifdef FPGA_CFG_LOADER_CRC_EN
                    cfg_err  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef FPGA_CFG_LOADER_CRC_EN
    assign cfg_err = 1'b0;
`endif

    assign cfg_busy       = (state == LOAD)
`ifdef FPGA_CFG_LOADER_CRC_EN
                          || (state == CRC)
`endif
                          ;
    assign brbselect      = cfg_q[TOTAL-1 -: BRB_W];
    assign bsbselect      = cfg_q[TOTAL-BRB_W-1 -: BSB_W];
    assign lbselect       = cfg_q[4*IO_W+LB_W-1 -: LB_W];
    assign leftioselect   = cfg_q[4*IO_W-1 -: IO_W];
    assign rightioselect  = cfg_q[3*IO_W-1 -: IO_W];
    assign topioselect    = cfg_q[2*IO_W-1 -: IO_W];
    assign bottomioselect = cfg_q[IO_W-1:0];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard testbench for fpga_cfg_loader
module tb_fpga_cfg_loader;

    localparam int BRB_W = 750;
    localparam int BSB_W = 1728;
    localparam int LB_W  = 80;
    localparam int IO_W  = 20;
    localparam int TOTAL = BRB_W + BSB_W + LB_W + 4 * IO_W;
    localparam logic [7:0] SYNC = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n, cfg_bit, cfg_valid, cfg_abort;
    logic             cfg_ready, cfg_busy, cfg_done, cfg_err;
    logic [BRB_W-1:0] brbselect;
    logic [BSB_W-1:0] bsbselect;
    logic [LB_W-1:0]  lbselect;
    logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;

    int               n_pass  = 0;
    int               n_total = 0;
    logic [TOTAL-1:0] exp_q[$];
    logic [TOTAL-1:0] last_commit = '0;
    logic [TOTAL-1:0] out_vec;

    assign out_vec = {brbselect, bsbselect, lbselect, leftioselect,
                      rightioselect, topioselect, bottomioselect};

    fpga_cfg_loader #(.SYNC_WORD(SYNC), .BRB_W(BRB_W), .BSB_W(BSB_W), .LB_W(LB_W), .IO_W(IO_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_abort(cfg_abort),
        .brbselect(brbselect), .bsbselect(bsbselect), .lbselect(lbselect),
        .leftioselect(leftioselect), .rightioselect(rightioselect),
        .topioselect(topioselect), .bottomioselect(bottomioselect),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic int first_diff(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b);
        for (int i = TOTAL - 1; i >= 0; i--) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] crc8(input logic [TOTAL-1:0] p);
        logic [7:0] c = 8'h00;
        for (int i = TOTAL - 1; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ p[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    function automatic logic [TOTAL-1:0] rand_payload();
        logic [TOTAL-1:0] p;
        for (int i = 0; i < TOTAL; i++) p[i] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic send_bit(input logic b, input bit stall);
        if (stall) begin
            cfg_valid = 1'b0;
            cfg_bit   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        cfg_valid = 1'b1;
        cfg_bit   = b;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_sync(input bit stall);
        logic [7:0] s = SYNC;
        for (int i = 7; i >= 0; i--) send_bit(s[i], stall);
    endtask

    task automatic send_frame(input logic [TOTAL-1:0] p, input bit stall, input bit corrupt, input string name);
        logic [TOTAL-1:0] e;
        logic [7:0]       c;
        send_sync(stall);
        if (!corrupt) exp_q.push_back(p);
        for (int i = TOTAL - 1; i >= 0; i--) send_bit(p[i], stall);
        c = crc8(p);
        if (corrupt) c[0] = ~c[0];
`ifdef FPGA_CFG_LOADER_CRC_EN
        for (int i = 7; i >= 0; i--) send_bit(c[i], stall);
`endif
        if (corrupt) begin
            n_total++;
            if (cfg_err !== 1'b1) $display("FAIL %s err: got %b want 1", name, cfg_err);
            else n_pass++;
            n_total++;
            if (cfg_done !== 1'b0) $display("FAIL %s done: got %b want 0", name, cfg_done);
            else n_pass++;
            n_total++;
            if (out_vec !== last_commit)
                $display("FAIL %s held: outputs differ at bit %0d got %b want %b", name,
                         first_diff(out_vec, last_commit), out_vec[first_diff(out_vec, last_commit)],
                         last_commit[first_diff(out_vec, last_commit)]);
            else n_pass++;
            n_total++;
            if (cfg_busy !== 1'b0 || cfg_ready !== 1'b1)
                $display("FAIL %s hunt: got busy=%b ready=%b want busy=0 ready=1", name, cfg_busy, cfg_ready);
            else n_pass++;
        end else begin
            n_total++;
            if (cfg_ready !== 1'b0) $display("FAIL %s commit latency: ready got %b want 0", name, cfg_ready);
            else n_pass++;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_total++;
            if (out_vec !== e)
                $display("FAIL %s outputs: differ at bit %0d got %b want %b", name,
                         first_diff(out_vec, e), out_vec[first_diff(out_vec, e)], e[first_diff(out_vec, e)]);
            else n_pass++;
            n_total++;
            if (cfg_done !== 1'b1 || cfg_err !== 1'b0)
                $display("FAIL %s flags: got done=%b err=%b want done=1 err=0", name, cfg_done, cfg_err);
            else n_pass++;
            n_total++;
            if (cfg_busy !== 1'b0 || cfg_ready !== 1'b1)
                $display("FAIL %s after commit: got busy=%b ready=%b want busy=0 ready=1", name, cfg_busy, cfg_ready);
            else n_pass++;
            last_commit = e;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0; cfg_abort = 1'b0;
        #22;
        n_total++;
        if (out_vec !== '0) $display("FAIL reset outputs: nonzero at bit %0d want 0", first_diff(out_vec, '0));
        else n_pass++;
        n_total++;
        if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || cfg_busy !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL reset flags: got done=%b err=%b busy=%b ready=%b want 0 0 0 1",
                     cfg_done, cfg_err, cfg_busy, cfg_ready);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [TOTAL-1:0] p = '0;
        p[TOTAL-BRB_W] = 1'b1;
        send_frame(p, 1'b0, 1'b0, "single");
        n_total++;
        if (brbselect !== BRB_W'(1) || bsbselect !== '0 || lbselect !== '0 || bottomioselect !== '0)
            $display("FAIL single brb: got brb[3:0]=%h want 1 with others 0", brbselect[3:0]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [TOTAL-1:0] p = rand_payload();
        logic [TOTAL-1:0] q = rand_payload();
        send_frame(p, 1'b0, 1'b0, "b2b_p");
        send_frame(q, 1'b0, 1'b0, "b2b_q");
        send_frame(p, 1'b1, 1'b0, "stall_p");
    endtask

    task automatic test_abort();
        send_sync(1'b0);
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0; cfg_valid = 1'b0;
        n_total++;
        if (cfg_busy !== 1'b0) $display("FAIL abort busy: got %b want 0", cfg_busy);
        else n_pass++;
        n_total++;
        if (out_vec !== last_commit) $display("FAIL abort held: outputs differ at bit %0d", first_diff(out_vec, last_commit));
        else n_pass++;
        n_total++;
        if (cfg_done !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL abort flags: got done=%b err=%b want 0 0", cfg_done, cfg_err);
        else n_pass++;
        send_frame(rand_payload(), 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid();
        send_sync(1'b0);
        for (int i = 0; i < 1000; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_vec !== '0 || cfg_done !== 1'b0 || cfg_busy !== 1'b0)
            $display("FAIL midreset clear: got done=%b busy=%b diff bit %0d want all 0",
                     cfg_done, cfg_busy, first_diff(out_vec, '0));
        else n_pass++;
        #3 rst_n = 1'b1;
        last_commit = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 1500; i++) send_bit(1'((i % 4) < 2), 1'b0);
        n_total++;
        if (cfg_done !== 1'b0 || cfg_busy !== 1'b0 || out_vec !== '0)
            $display("FAIL midreset nosync: got done=%b busy=%b want 0 0 with zero outputs", cfg_done, cfg_busy);
        else n_pass++;
    endtask

    task automatic test_sync_in_payload();
        logic [TOTAL-1:0] p = rand_payload();
        logic [7:0]       s = SYNC;
        for (int k = 0; k < 8; k++) p[TOTAL-9-k] = s[7-k];
        send_frame(p, 1'b0, 1'b0, "sync_in_payload");
    endtask

    task automatic test_crc_error();
        send_frame(rand_payload(), 1'b0, 1'b1, "crc_bad");
        send_frame(rand_payload(), 1'b0, 1'b0, "crc_good");
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_abort();
        test_reset_mid();
        test_sync_in_payload();
`ifdef FPGA_CFG_LOADER_CRC_EN
        test_crc_error();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5, the non-zero preamble that opens a frame.
REQ-002 Parameter BRB_W, default 750, the routing-block select width.
REQ-003 Parameter BSB_W, default 1728, the switch-block select width.
REQ-004 Parameter LB_W, default 80, the logic-block select width.
REQ-005 Parameter IO_W, default 20, the width of each of the four IO select vectors.
REQ-006 clk  input  1  Single clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  Asynchronous, active-low reset.
REQ-008 cfg_bit  input  1  Serial configuration data.
REQ-009 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-010 cfg_ready  output  1  Loader accepts a bit this cycle.
REQ-011 cfg_abort  input  1  Synchronous discard of the frame in progress.
REQ-012 brbselect, bsbselect, lbselect  output  BRB_W, BSB_W, LB_W  Committed fabric configuration.
REQ-013 leftioselect, rightioselect, topioselect, bottomioselect  output  IO_W each  Committed IO configuration.
REQ-014 cfg_busy  output  1  Frame in progress (state LOAD or CRC).
REQ-015 cfg_done  output  1  A frame has been committed.
REQ-016 cfg_err  output  1  The most recent frame failed its check.

Function
REQ-017 A bit transfers on a rising edge where cfg_valid and cfg_ready are both 1; cfg_valid low stalls the loader with no state change.
REQ-018 TOTAL = BRB_W+BSB_W+LB_W+4*IO_W (2638 by default); the payload is the concatenation {brb, bsb, lb, left, right, top, bottom}, sent MSB first.
REQ-019 States: HUNT, LOAD, CRC, COMMIT; reset state is HUNT.
REQ-020 HUNT: accepted bits shift into an 8-bit sync register; when it equals SYNC_WORD, go to LOAD, clear the bit counter, clear the CRC, and clear cfg_done.
REQ-021 LOAD: each accepted bit shifts into the LSB of a TOTAL-bit shadow register and increments a 12-bit counter; a sync pattern inside the payload is ignored.
REQ-022 When the TOTAL-th payload bit is accepted, go to CRC if CFG_CRC_EN is defined, otherwise to COMMIT.
REQ-023 cfg_ready is 1 in HUNT, LOAD and CRC, and 0 in COMMIT.
REQ-024 COMMIT lasts one cycle: the outputs load the shadow, cfg_done goes to 1, cfg_err goes to 0, the sync register clears, and the state returns to HUNT.
REQ-025 Outputs change only in COMMIT; the shadow contents are never visible on the outputs before commit.
REQ-026 cfg_abort=1 in any state returns to HUNT on the next edge and clears the counter and sync register; outputs, cfg_done and cfg_err are unchanged; abort takes priority over a simultaneous transfer.
REQ-027 cfg_done stays 1 until the next sync match or reset; cfg_err stays 1 until the next successful commit or reset.

Reset
REQ-028 rst_n=0 asynchronously forces state HUNT, zeros the counter, sync register, shadow and CRC, and zeros every select output, cfg_done, cfg_err and cfg_busy.
REQ-029 Reset asserted mid-frame discards the frame; loading after release requires a fresh SYNC_WORD.

Configuration
REQ-030 Macro FPGA_CFG_LOADER_CRC_EN (referred to above as CFG_CRC_EN) SHALL select the frame check: defined -> CRC-8 (polynomial 0x07, initial value 0x00) over the payload bits in arrival order, followed by 8 received CRC bits MSB first.
REQ-031 With the macro defined, a match moves to COMMIT; a mismatch sets cfg_err=1, skips the commit, and returns to HUNT on the edge that accepts the 8th CRC bit.
REQ-032 With the macro undefined, there is no CRC state or logic, cfg_err is tied to 0, and every complete frame commits.

Verification
REQ-033 Send A5, then TOTAL payload bits with only brbselect[0]=1 (and the correct CRC when enabled) -> one COMMIT cycle with cfg_ready=0; brbselect=1 and all other outputs 0; cfg_done=1.
REQ-034 Send a frame with cfg_valid toggling every other cycle -> the result is identical to the back-to-back case, and the commit follows the last accepted bit by exactly 1 cycle.
REQ-035 Send A5, 100 payload bits, then cfg_abort=1 -> state HUNT; previous outputs held; a following full frame commits correctly.
REQ-036 Drop rst_n at payload bit 1000 -> all outputs 0 immediately; 1500 further bits without a sync cause no commit.
REQ-037 With the CRC macro defined, send a frame with CRC bit 0 flipped -> cfg_err=1, outputs unchanged, cfg_done=0; a following good frame gives cfg_err=0 and cfg_done=1.
REQ-038 Send a payload containing A5 at bit 8 -> no resync; the bit counter reaches TOTAL and the payload is committed verbatim.
